// File: rtl/line_fetch.sv
// Line fetcher: reads one video line pixel-by-pixel from memory and streams it out.
// Optional start/end-of-line markers (pix_sol/pix_eol) when LINE_FETCH_SOL_EOL_EN is defined.
module line_fetch #(
  parameter int unsigned LINE_NUMBER_WIDTH = 16,
  parameter int unsigned PIXELS_PER_LINE   = 128,
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned DATA_WIDTH        = 24
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic [LINE_NUMBER_WIDTH-1:0] line_number,
  output logic                         line_data_ready,
  output logic                         mem_rd_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_rd_gnt,
  input  logic                         mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [DATA_WIDTH-1:0]        pix_data
`ifdef LINE_FETCH_SOL_EOL_EN
  ,
  output logic                         pix_sol,
  output logic                         pix_eol
`endif
);

  localparam int unsigned IDX_W = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DONE
  } state_t;

  state_t                       state;
  logic [LINE_NUMBER_WIDTH-1:0] line_q;
  logic [IDX_W-1:0]             idx_q;
  logic [ADDR_WIDTH-1:0]        start_addr_c;
  logic [ADDR_WIDTH-1:0]        next_addr_c;

  // Address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
  assign start_addr_c = ADDR_WIDTH'(line_number) * ADDR_WIDTH'(PIXELS_PER_LINE);
  assign next_addr_c  = ADDR_WIDTH'(line_q) * ADDR_WIDTH'(PIXELS_PER_LINE)
                      + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      line_q          <= '0;
      idx_q           <= '0;
      mem_addr        <= '0;
      mem_rd_req      <= 1'b0;
      pix_valid       <= 1'b0;
      pix_data        <= '0;
      line_data_ready <= 1'b0;
`ifdef LINE_FETCH_SOL_EOL_EN
      pix_sol         <= 1'b0;
      pix_eol         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            line_q     <= line_number;
            idx_q      <= '0;
            mem_addr   <= start_addr_c;
            mem_rd_req <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_rd_gnt) begin
            mem_rd_req <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rd_valid) begin
            pix_data  <= mem_rd_data;
            pix_valid <= 1'b1;
`ifdef LINE_FETCH_SOL_EOL_EN
            pix_sol   <= (idx_q == '0);
            pix_eol   <= (idx_q == LAST_IDX);
`endif
            state     <= OUT;
          end
        end
        OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
`ifdef LINE_FETCH_SOL_EOL_EN
            pix_sol   <= 1'b0;
            pix_eol   <= 1'b0;
`endif
            if (idx_q == LAST_IDX) begin
              line_data_ready <= 1'b1;
              state           <= DONE;
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              mem_addr   <= next_addr_c;
              mem_rd_req <= 1'b1;
              state      <= REQ;
            end
          end
        end
        DONE: begin
          line_data_ready <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch: table of whole-line scenarios plus a mid-line reset sequence.
module tb_line_fetch;
  localparam int unsigned LNW = 16;
  localparam int unsigned PPL = 128;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 24;
  localparam int unsigned NV  = 5;

  logic           clk = 1'b0;
  logic           nrst;
  logic           en;
  logic [LNW-1:0] line_number;
  logic           line_data_ready;
  logic           mem_rd_req;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd_gnt;
  logic           mem_rd_valid;
  logic [DW-1:0]  mem_rd_data;
  logic           pix_valid;
  logic           pix_ready;
  logic [DW-1:0]  pix_data;
`ifdef LINE_FETCH_SOL_EOL_EN
  logic           pix_sol;
  logic           pix_eol;
`endif

  line_fetch #(
    .LINE_NUMBER_WIDTH(LNW),
    .PIXELS_PER_LINE  (PPL),
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .line_number    (line_number),
    .line_data_ready(line_data_ready),
    .mem_rd_req     (mem_rd_req),
    .mem_addr       (mem_addr),
    .mem_rd_gnt     (mem_rd_gnt),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data)
`ifdef LINE_FETCH_SOL_EOL_EN
    ,
    .pix_sol        (pix_sol),
    .pix_eol        (pix_eol)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ln;
    int          gd;
    int          vd;
    int          rd;
    logic [15:0] base;
  } vec_t;

  vec_t tbl[NV];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   ldr_pulses = 0;

  always @(negedge clk) if (nrst && line_data_ready) ldr_pulses++;

  function automatic logic [23:0] pix_of(input logic [15:0] a);
    return {8'hA5, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Runs one full line starting from IDLE with en/line_number already presented.
  task automatic run_line(input vec_t v, input logic [15:0] next_ln, input logic next_en);
    logic [15:0] a;
    tick();
    chk("start_req", 32'(mem_rd_req), 32'd1);
    en          = 1'b0;
    line_number = ~v.ln;
    for (int i = 0; i < int'(PPL); i++) begin
      a = 16'(v.base + 16'(i));
      chk("addr", 32'(mem_addr), 32'(a));
      for (int g = 0; g < v.gd; g++) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = 24'h3C0000 | 24'(i);
        tick();
        chk("addr_hold", 32'(mem_addr), 32'(a));
        chk("req_hold", 32'(mem_rd_req), 32'd1);
      end
      mem_rd_valid = 1'b0;
      mem_rd_gnt   = 1'b1;
      tick();
      mem_rd_gnt = 1'b0;
      chk("req_drop", 32'(mem_rd_req), 32'd0);
      for (int d = 0; d < v.vd; d++) tick();
      mem_rd_valid = 1'b1;
      mem_rd_data  = pix_of(a);
      tick();
      mem_rd_valid = 1'b0;
      chk("pix_valid", 32'(pix_valid), 32'd1);
      chk("pix_data", 32'(pix_data), 32'(pix_of(a)));
`ifdef LINE_FETCH_SOL_EOL_EN
      chk("pix_sol", 32'(pix_sol), 32'(i == 0));
      chk("pix_eol", 32'(pix_eol), 32'(i == int'(PPL) - 1));
`endif
      for (int r = 0; r < v.rd; r++) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = 24'h3C0000 | 24'(r);
        tick();
        chk("stall_data", 32'(pix_data), 32'(pix_of(a)));
        chk("stall_valid", 32'(pix_valid), 32'd1);
        chk("stall_noreq", 32'(mem_rd_req), 32'd0);
      end
      mem_rd_valid = 1'b0;
      pix_ready    = 1'b1;
      tick();
      pix_ready = 1'b0;
    end
    chk("ldr_pulse", 32'(line_data_ready), 32'd1);
    chk("ldr_novalid", 32'(pix_valid), 32'd0);
    line_number = next_ln;
    en          = next_en;
    tick();
    chk("ldr_single", 32'(line_data_ready), 32'd0);
    chk("gap_noreq", 32'(mem_rd_req), 32'd0);
  endtask

  initial begin
    tbl[0] = '{ln: 16'd5,   gd: 0, vd: 0, rd: 0,  base: 16'd640};
    tbl[1] = '{ln: 16'd127, gd: 0, vd: 0, rd: 0,  base: 16'd16256};
    tbl[2] = '{ln: 16'd0,   gd: 0, vd: 0, rd: 0,  base: 16'd0};
    tbl[3] = '{ln: 16'd600, gd: 1, vd: 2, rd: 1,  base: 16'd11264};
    tbl[4] = '{ln: 16'd511, gd: 4, vd: 0, rd: 10, base: 16'd65408};

    nrst         = 1'b0;
    en           = 1'b0;
    line_number  = '0;
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    pix_ready    = 1'b0;
    repeat (3) tick();
    chk("rst_req", 32'(mem_rd_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_ldr", 32'(line_data_ready), 32'd0);
    nrst = 1'b1;
    tick();
    chk("idle_noreq", 32'(mem_rd_req), 32'd0);

    // Partial line on line 9, reset while pixel 60 is presented.
    line_number = 16'd9;
    en          = 1'b1;
    tick();
    en = 1'b0;
    chk("l9_req", 32'(mem_rd_req), 32'd1);
    chk("l9_addr", 32'(mem_addr), 32'd1152);
    for (int i = 0; i <= 60; i++) begin
      mem_rd_gnt = 1'b1;
      tick();
      mem_rd_gnt   = 1'b0;
      mem_rd_valid = 1'b1;
      mem_rd_data  = pix_of(16'(1152 + i));
      tick();
      mem_rd_valid = 1'b0;
      if (i < 60) begin
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
      end
    end
    chk("p60_valid", 32'(pix_valid), 32'd1);
    chk("p60_data", 32'(pix_data), 32'(pix_of(16'd1212)));
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_data", 32'(pix_data), 32'd0);
    chk("arst_req", 32'(mem_rd_req), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_ldr", 32'(line_data_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_hold_ldr", 32'(line_data_ready), 32'd0);
    end
    line_number = tbl[0].ln;
    en          = 1'b1;
    nrst        = 1'b1;
    chk("no_partial_ldr", 32'(ldr_pulses), 32'd0);

    for (int k = 0; k < int'(NV); k++) begin
      if (k < int'(NV) - 1) run_line(tbl[k], tbl[k+1].ln, 1'b1);
      else                  run_line(tbl[k], 16'd0, 1'b0);
    end

    repeat (3) tick();
    chk("final_idle", 32'(mem_rd_req), 32'd0);
    chk("ldr_count", 32'(ldr_pulses), 32'(NV));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
